spi_cfg_responder: RTL

- SPI responder (slave) for the configuration link that the FPGA-side SPI controller drives toward the ADC chip.
- Used in the chip-side model and in loopback/bring-up builds.
- Oversamples the sclk/csn/mosi pins on the system clock, assembles N_bit-bit MSB-first frames, and checks the frame length.
- Presents each accepted word with a one-cycle valid strobe and shifts the last accepted word back out on miso for readback.

---
 rtl/spi_cfg_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_cfg_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration responder: frame length,
// synchronizer depth, FSM encoding and the bit-counter width helper.
package spi_cfg_pkg;

  localparam int SPI_N_BIT   = 96;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Room for N_bit+1 so an overrun frame saturates instead of wrapping to N_bit.
  function automatic int bitcnt_w(input int n_bit);
    return $clog2(n_bit + 2);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Per-pin synchronizer (SYNC_STAGES flops) plus one edge-detect flop;
// reset level is chosen per pin so no false edge appears out of reset.
module spi_pin_sync
  import spi_cfg_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES:0] sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= {(SYNC_STAGES + 1){RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], pin_i};
    end
  end

  always_comb begin
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    fall_o  = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
  end

endmodule

// File: rtl/spi_cfg_responder.sv
// SPI mode-0 responder: oversamples the pins on clk, assembles MSB-first
// frames, accepts only exact-length frames and reads the last word back on miso.
module spi_cfg_responder
  import spi_cfg_pkg::*;
#(
  parameter int N_bit = SPI_N_BIT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             spi_sclk,
  input  logic             spi_csn,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [N_bit-1:0] rdata,
  output logic             vld,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int              BC_W        = bitcnt_w(N_bit);
  localparam logic [BC_W-1:0] BC_FULL     = BC_W'(N_bit);
  localparam logic [BC_W-1:0] BC_SAT      = BC_W'(N_bit + 1);
  localparam logic [1:0]      SETTLE_DONE = 2'(SYNC_STAGES);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_pins;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .nrst(nrst), .pin_i(spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .nrst(nrst), .pin_i(spi_csn),
    .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  // mosi level comes from the same stage as sclk so it lines up with sclk_rise.
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .nrst(nrst), .pin_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_pins = &{sclk_lvl, mosi_rise, mosi_fall, 1'b0};

  state_e             state_q, state_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [N_bit-1:0]   rx_q, rx_d;
  logic [N_bit-1:0]   tx_q, tx_d;
  logic [N_bit-1:0]   rdata_q, rdata_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [1:0]         settle_q, settle_d;
  logic               armed_q, armed_d;
  logic               frame_ok;

  // A low csn still in the synchronizer after reset is not a fresh frame start:
  // only arm once the synchronizer has flushed and csn is genuinely high.
  always_comb begin
    settle_d = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == SETTLE_DONE) & csn_lvl);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csn_fall && armed_q) state_d = RECV;
      RECV:    if (csn_rise) state_d = CHECK;
      CHECK:   state_d = csn_fall ? RECV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RECV);
    spi_miso = (state_q == RECV) ? tx_q[N_bit-1] : 1'b0;
  end

  assign frame_ok = (state_q == CHECK) && (bitcnt_q == BC_FULL);

  always_comb begin
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    rdata_d  = rdata_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    fcnt_d   = fcnt_q;
    case (state_q)
      IDLE: begin
        if (csn_fall && armed_q) begin
          bitcnt_d = '0;
          tx_d     = rdata_q;
        end
      end
      RECV: begin
        // csn_rise wins over any sclk edge seen in the same cycle.
        if (!csn_rise) begin
          if (sclk_rise) begin
            rx_d = {rx_q[N_bit-2:0], mosi_lvl};
            if (bitcnt_q != BC_SAT) bitcnt_d = bitcnt_q + 1'b1;
          end
          if (sclk_fall) tx_d = {tx_q[N_bit-2:0], 1'b0};
        end
      end
      CHECK: begin
        if (frame_ok) begin
          rdata_d = rx_q;
          vld_d   = 1'b1;
          fcnt_d  = fcnt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
        // Back-to-back frame: read back the word being accepted right now.
        if (csn_fall) begin
          bitcnt_d = '0;
          tx_d     = frame_ok ? rx_q : rdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bitcnt_q <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      rdata_q  <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      rdata_q  <= rdata_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  assign rdata     = rdata_q;
  assign vld       = vld_q;
  assign err       = err_q;
  assign frame_cnt = fcnt_q;

endmodule
